paillier_task_dispatcher: RTL and testbench
===========================================

// Module: paillier_task_dispatcher
// PURPOSE
//  Ingress counterpart of the per-block result FIFOs: takes the K-bit operand stream fetched by the
//  AXI-FULL master and fans it out round-robin to BLOCK_COUNT paillier_top cores.
//  Per task: issue task_req/task_cmd, stream operand A then operand B (N words each), advance block.
//  Tracks per-core busy (req..task_end) and pulses done when all tasks are dispatched and drained.
// PARAMETERS
//  BLOCK_COUNT  24   number of paillier_top cores
//  K            128  operand word width (bits)
//  N            32   words per operand
//  TASK_W       16   width of task count
// PORTS
//  clk          in   1              single clock domain
//  rst          in   1              asynchronous reset, active-high
//  start        in   1              one-cycle start pulse; ignored while busy
//  mode         in   2              0 ENC(m,r) 1 DEC(c) 2 HOMO_ADD(c1,c2) 3 SCALAR_MUL(c1,const)
//  num_tasks    in   TASK_W         tasks in this run; sampled on accepted start
//  s_valid      in   1              operand stream valid
//  s_ready      out  1              operand stream ready
//  s_data       in   K              operand word, LSW first
//  task_req     out  BLOCK_COUNT    one-hot, one-cycle task request
//  task_cmd     out  2              command, = latched mode, shared by all cores
//  op_data      out  K              registered operand word, shared bus
//  op_a_valid   out  BLOCK_COUNT    one-hot strobe: op_data is operand A word (m/c/c1)
//  op_b_valid   out  BLOCK_COUNT    one-hot strobe: op_data is operand B word (r/c2/const)
//  task_end     in   BLOCK_COUNT    per-core completion pulse
//  busy         out  1              run in progress
//  done         out  1              one-cycle pulse at run end
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, blk_ptr=0, task_cnt=0, core_busy=0; same on rst asserted mid-run
//    (in-flight words dropped, no done).
//  FSM IDLE -> (start) latch mode/num_tasks, busy=1:
//    - num_tasks==0 -> FIN.
//    - else -> WAIT.
//  WAIT: if core_busy[blk_ptr]==0 -> REQ, else stay (s_ready=0).
//  REQ: task_req[blk_ptr]=1 one cycle, set core_busy[blk_ptr], word_cnt=0 -> OPA.
//  OPA: s_ready=1; each s_valid&s_ready beat: op_data<=s_data, op_a_valid[blk_ptr]<=1 next cycle
//    (latency 1).
//    After N beats: DEC -> NEXT, else -> OPB.
//  OPB: as OPA with op_b_valid; after N beats -> NEXT.
//  NEXT: task_cnt++, blk_ptr wraps BLOCK_COUNT-1 -> 0.
//    - task_cnt==num_tasks -> FIN.
//    - else -> WAIT.
//  FIN: wait core_busy==0; then done=1 one cycle, busy=0 -> IDLE.
//  Backpressure: s_valid low in OPA/OPB stalls word_cnt; the strobe gaps match.
//    Cores accept non-contiguous words.
//  s_ready is 0 in every state except OPA/OPB; no data is accepted before REQ.
//  Ordering: s_ready drops combinationally in the cycle after the Nth beat.
//    The beat after the last B word is never consumed into the wrong block.
//  task_end[i] clears core_busy[i]. A task_end on a non-busy core is ignored.
//    Ends on several cores in one cycle all clear.
//    task_end[blk_ptr] arriving in WAIT lets REQ issue the next cycle.
//  Strobes are one-hot or zero. op_a_valid and op_b_valid are never high together.
//  start in any state but IDLE is ignored; mode changes mid-run are ignored.
//  Counters: word_cnt $clog2(N)+1 bits, blk_ptr $clog2(BLOCK_COUNT) bits, task_cnt TASK_W bits.
// STRUCTURE
//  paillier_pkg: typedef enum logic[1:0] paillier_cmd_t {ENC,DEC,HOMO_ADD,SCALAR_MUL};
//    FSM state enum; disp_state_t.
//  Single module; core_busy bookkeeping is inline bit set/clear, no sub-module.
// TESTING
//  - BLOCK_COUNT=4, N=4, mode=ENC, num_tasks=2, s_valid always 1, cores end at once:
//    task_req=0001 then 0010; 4 op_a + 4 op_b strobes each; done after both task_end.
//  - mode=DEC, num_tasks=1: exactly 4 op_a_valid[0], zero op_b_valid; s_ready low after 4th beat.
//  - num_tasks=6 on 4 cores, core 0 holds task_end 100 cycles:
//    5th req waits in WAIT with s_ready=0 until task_end[0], then task_req=0001.
//  - s_valid toggled 1010...: op_data equals s_data delayed 1 cycle;
//    strobe count per operand exactly N; word order preserved.
//  - num_tasks=0: done 2 cycles after start, no task_req.
//    start during an active run: ignored, no double-count.
//  - rst pulsed mid-OPB: all outputs 0 next cycle, no done;
//    a fresh start then dispatches from block 0.

Source files
------------

// File: rtl/paillier_pkg.sv
// Shared types for the Paillier task dispatcher: core command encoding and dispatcher FSM states.
package paillier_pkg;

  typedef enum logic [1:0] {
    ENC        = 2'd0,
    DEC        = 2'd1,
    HOMO_ADD   = 2'd2,
    SCALAR_MUL = 2'd3
  } paillier_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_REQ,
    S_OPA,
    S_OPB,
    S_NEXT,
    S_FIN
  } disp_state_t;

endpackage

// File: rtl/paillier_task_dispatcher.sv
// Fans the fetched operand stream out round-robin to BLOCK_COUNT Paillier cores,
// one task at a time, tracking per-core busy until each core reports task_end.
module paillier_task_dispatcher
  import paillier_pkg::*;
#(
  parameter int BLOCK_COUNT = 24,
  parameter int K           = 128,
  parameter int N           = 32,
  parameter int TASK_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [TASK_W-1:0]      num_tasks,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [K-1:0]           s_data,
  output logic [BLOCK_COUNT-1:0] task_req,
  output logic [1:0]             task_cmd,
  output logic [K-1:0]           op_data,
  output logic [BLOCK_COUNT-1:0] op_a_valid,
  output logic [BLOCK_COUNT-1:0] op_b_valid,
  input  logic [BLOCK_COUNT-1:0] task_end,
  output logic                   busy,
  output logic                   done
);

  localparam int PTR_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1;
  localparam int WC_W  = $clog2(N) + 1;
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'(N - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BLOCK_COUNT - 1);

  disp_state_t            state_reg, state_next;
  paillier_cmd_t          cmd_reg;
  logic [TASK_W-1:0]      num_tasks_reg, task_cnt_reg, task_cnt_inc;
  logic [PTR_W-1:0]       blk_ptr_reg;
  logic [WC_W-1:0]        word_cnt_reg;
  logic [BLOCK_COUNT-1:0] core_busy_reg, blk_sel;
  logic [K-1:0]           op_data_reg;
  logic [BLOCK_COUNT-1:0] op_a_valid_reg, op_b_valid_reg;
  logic                   done_reg;
  logic                   beat, last_beat, blk_free, accept_start;

  assign blk_sel      = BLOCK_COUNT'(1) << blk_ptr_reg;
  assign beat         = s_valid & s_ready;
  assign last_beat    = beat & (word_cnt_reg == WC_LAST);
  // A task_end arriving this cycle already frees the target core for REQ.
  assign blk_free     = ~core_busy_reg[blk_ptr_reg] | task_end[blk_ptr_reg];
  assign accept_start = (state_reg == S_IDLE) & start;
  assign task_cnt_inc = task_cnt_reg + TASK_W'(1);

  assign task_cmd   = cmd_reg;
  assign op_data    = op_data_reg;
  assign op_a_valid = op_a_valid_reg;
  assign op_b_valid = op_b_valid_reg;
  assign done       = done_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (start) state_next = (num_tasks == '0) ? S_FIN : S_WAIT;
      S_WAIT: if (blk_free) state_next = S_REQ;
      S_REQ:  state_next = S_OPA;
      S_OPA:  if (last_beat) state_next = (cmd_reg == DEC) ? S_NEXT : S_OPB;
      S_OPB:  if (last_beat) state_next = S_NEXT;
      S_NEXT: state_next = (task_cnt_inc == num_tasks_reg) ? S_FIN : S_WAIT;
      S_FIN:  if (core_busy_reg == '0) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    task_req = '0;
    busy     = (state_reg != S_IDLE);
    case (state_reg)
      S_REQ:        task_req = blk_sel;
      S_OPA, S_OPB: s_ready  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_reg        <= ENC;
      num_tasks_reg  <= '0;
      task_cnt_reg   <= '0;
      blk_ptr_reg    <= '0;
      word_cnt_reg   <= '0;
      op_data_reg    <= '0;
      op_a_valid_reg <= '0;
      op_b_valid_reg <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg       <= (state_reg == S_FIN) && (core_busy_reg == '0);
      op_a_valid_reg <= (state_reg == S_OPA && beat) ? blk_sel : '0;
      op_b_valid_reg <= (state_reg == S_OPB && beat) ? blk_sel : '0;
      if (beat) op_data_reg <= s_data;
      if (accept_start) begin
        cmd_reg       <= paillier_cmd_t'(mode);
        num_tasks_reg <= num_tasks;
        task_cnt_reg  <= '0;
        blk_ptr_reg   <= '0;
      end
      case (state_reg)
        S_REQ: word_cnt_reg <= '0;
        S_OPA, S_OPB:
          if (beat) word_cnt_reg <= last_beat ? '0 : word_cnt_reg + WC_W'(1);
        S_NEXT: begin
          task_cnt_reg <= task_cnt_inc;
          blk_ptr_reg  <= (blk_ptr_reg == PTR_LAST) ? '0 : blk_ptr_reg + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Set on REQ wins over a same-cycle task_end, which can only belong to an older task.
  generate
    for (genvar gi = 0; gi < BLOCK_COUNT; gi++) begin : g_core_busy
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          core_busy_reg[gi] <= 1'b0;
        else if (state_reg == S_REQ && blk_ptr_reg == PTR_W'(gi))
          core_busy_reg[gi] <= 1'b1;
        else if (task_end[gi])
          core_busy_reg[gi] <= 1'b0;
      end
    end
  endgenerate

endmodule

// File: tb/tb_paillier_task_dispatcher.sv
// Scoreboard bench for paillier_task_dispatcher on 4 cores with 4-word operands.
module tb_paillier_task_dispatcher;
  import paillier_pkg::*;

  localparam int BC = 4;
  localparam int KW = 32;
  localparam int NW = 4;
  localparam int TW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [TW-1:0] num_tasks;
  logic          s_valid;
  logic          s_ready;
  logic [KW-1:0] s_data;
  logic [BC-1:0] task_req;
  logic [1:0]    task_cmd;
  logic [KW-1:0] op_data;
  logic [BC-1:0] op_a_valid, op_b_valid;
  logic [BC-1:0] task_end;
  logic          busy, done;

  paillier_task_dispatcher #(.BLOCK_COUNT(BC), .K(KW), .N(NW), .TASK_W(TW)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .num_tasks(num_tasks),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .task_req(task_req), .task_cmd(task_cmd), .op_data(op_data),
    .op_a_valid(op_a_valid), .op_b_valid(op_b_valid), .task_end(task_end),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          kind;   // 0 = operand A, 1 = operand B
    int          blk;
    logic [KW-1:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state (written only by the monitor)
  bit   m_active = 0;
  int   m_mode = 0, m_ntasks = 0, m_req = 0, m_beats = 0, m_done_cnt = 0;
  int   cnt_a[BC], cnt_b[BC], req_n[BC], req_cyc[16];
  int   te0_cyc = -1;
  logic [BC-1:0] first_req;

  // Core model state
  int   end_n[BC], age[BC], hold[BC];
  logic [BC-1:0] rel_mask = '0;

  // Stream driver control
  bit stream_en = 0;
  bit toggle = 0;

  function automatic int per_task_f(int md);
    return (md == 1) ? NW : 2 * NW;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] md, input int n);
    start = 1'b1;
    mode = md;
    num_tasks = TW'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done_change(input int d0, input int bound);
    for (int i = 0; i < bound && m_done_cnt == d0; i++) tick();
  endtask

  task automatic wait_strobes(input int total, input int bound);
    int s;
    for (int i = 0; i < bound; i++) begin
      s = 0;
      for (int b = 0; b < BC; b++) s += cnt_a[b] + cnt_b[b];
      if (s >= total) break;
      tick();
    end
  endtask

  // Operand stream source
  initial begin
    s_valid = 1'b0;
    s_data = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!stream_en) s_valid = 1'b0;
      else if (toggle) s_valid = ~s_valid;
      else s_valid = 1'b1;
      s_data = $urandom;
    end
  end

  // Core model: each requested core ends hold[i] cycles later, or at once when released
  initial begin
    logic [BC-1:0] te;
    task_end = '0;
    for (int i = 0; i < BC; i++) begin end_n[i] = 0; age[i] = 0; hold[i] = 1000; end
    forever begin
      @(posedge clk);
      #2;
      te = '0;
      if (rst) begin
        for (int i = 0; i < BC; i++) begin end_n[i] = 0; age[i] = 0; end
      end else begin
        for (int i = 0; i < BC; i++) begin
          if (req_n[i] != end_n[i]) begin
            if (age[i] >= hold[i] || rel_mask[i]) begin
              te[i] = 1'b1;
              end_n[i]++;
              age[i] = 0;
            end else age[i]++;
          end
        end
      end
      task_end = te;
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    int pt, total;
    bit allowed, drained;
    logic [BC-1:0] exp_sel;
    exp_t e;
    cyc++;
    if (rst) begin
      q.delete();
      m_active = 0;
      m_req = 0;
      m_beats = 0;
      for (int i = 0; i < BC; i++) req_n[i] = 0;
    end else begin
      pt = per_task_f(m_mode);
      total = m_ntasks * pt;
      if ((op_a_valid | op_b_valid) != '0) begin
        checks++;
        if ((op_a_valid != '0 && op_b_valid != '0) ||
            !$onehot(op_a_valid | op_b_valid)) begin
          errors++;
          $display("FAIL strobe_onehot a=%b b=%b required one-hot", op_a_valid, op_b_valid);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL strobe_unexpected a=%b b=%b required no strobe", op_a_valid, op_b_valid);
        end else begin
          e = q.pop_front();
          exp_sel = BC'(1) << e.blk;
          if ((e.kind ? op_b_valid : op_a_valid) !== exp_sel ||
              (e.kind ? op_a_valid : op_b_valid) !== '0 ||
              op_data !== e.data || cyc != e.cyc + 1) begin
            errors++;
            $display("FAIL strobe_match a=%b b=%b data=%h cyc=%0d required kind=%0d sel=%b data=%h cyc=%0d",
                     op_a_valid, op_b_valid, op_data, cyc, e.kind, exp_sel, e.data, e.cyc + 1);
          end
        end
        for (int b = 0; b < BC; b++) begin
          if (op_a_valid[b]) cnt_a[b]++;
          if (op_b_valid[b]) cnt_b[b]++;
        end
      end
      if (task_req != '0) begin
        exp_sel = BC'(1) << (m_req % BC);
        checks++;
        if (!m_active || task_req !== exp_sel) begin
          errors++;
          $display("FAIL task_req got=%b required=%b active=%0d", task_req, exp_sel, m_active);
        end
        $display("req blk_mask=%b task=%0d cyc=%0d", task_req, m_req, cyc);
        if (m_req == 0) first_req = task_req;
        if (m_req < 16) req_cyc[m_req] = cyc;
        m_req++;
        for (int b = 0; b < BC; b++) if (task_req[b]) req_n[b]++;
      end
      if (m_active && task_end[0] && te0_cyc < 0) te0_cyc = cyc;
      allowed = m_active && (m_beats < total) && (m_req > m_beats / pt);
      if (s_ready) begin
        checks++;
        if (!allowed) begin
          errors++;
          $display("FAIL s_ready got=1 required=0 beats=%0d reqs=%0d", m_beats, m_req);
        end
      end
      if (s_valid && s_ready && allowed) begin
        e.kind = ((m_beats % pt) >= NW);
        e.blk = (m_beats / pt) % BC;
        e.data = s_data;
        e.cyc = cyc;
        q.push_back(e);
        m_beats++;
      end
      if (done) begin
        drained = 1;
        for (int b = 0; b < BC; b++) if (req_n[b] != end_n[b]) drained = 0;
        checks++;
        if (!m_active || m_req != m_ntasks || m_beats != total || !drained) begin
          errors++;
          $display("FAIL done_early got=1 active=%0d reqs=%0d/%0d beats=%0d/%0d drained=%0d",
                   m_active, m_req, m_ntasks, m_beats, total, drained);
        end
        $display("done tasks=%0d cyc=%0d", m_req, cyc);
        m_done_cnt++;
        m_active = 0;
      end
      if (start && !m_active) begin
        m_active = 1;
        m_mode = int'(mode);
        m_ntasks = int'(num_tasks);
        m_req = 0;
        m_beats = 0;
        te0_cyc = -1;
        first_req = '0;
        for (int b = 0; b < BC; b++) begin cnt_a[b] = 0; cnt_b[b] = 0; end
      end
    end
  end

  task automatic test_reset();
    tick();
    tick();
    for (int ph = 0; ph < 2; ph++) begin
      checks++;
      if (s_ready !== 1'b0 || task_req !== '0 || op_a_valid !== '0 || op_b_valid !== '0) begin
        errors++;
        $display("FAIL reset_handshake ph=%0d s_ready=%b req=%b a=%b b=%b required all 0",
                 ph, s_ready, task_req, op_a_valid, op_b_valid);
      end
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || op_data !== '0 || task_cmd !== 2'd0) begin
        errors++;
        $display("FAIL reset_status ph=%0d busy=%b done=%b data=%h cmd=%0d required all 0",
                 ph, busy, done, op_data, task_cmd);
      end
      rst = 1'b0;
      tick();
    end
  endtask

  task automatic test_enc_basic();
    int d0;
    int s;
    hold = '{1000, 1000, 1000, 1000};
    rel_mask = '0;
    stream_en = 1;
    toggle = 0;
    d0 = m_done_cnt;
    pulse_start(2'(ENC), 2);
    wait_strobes(16, 100);
    repeat (5) tick();
    checks++;
    if (cnt_a[0] != 4 || cnt_b[0] != 4 || cnt_a[1] != 4 || cnt_b[1] != 4) begin
      errors++;
      $display("FAIL enc_counts a0=%0d b0=%0d a1=%0d b1=%0d required 4 each",
               cnt_a[0], cnt_b[0], cnt_a[1], cnt_b[1]);
    end
    checks++;
    if (m_req != 2) begin
      errors++;
      $display("FAIL enc_reqs got=%0d required=2", m_req);
    end
    checks++;
    if (m_done_cnt != d0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL enc_hold_done dones=%0d busy=%b required 0 dones, busy=1", m_done_cnt - d0, busy);
    end
    rel_mask = 4'b0011;
    wait_done_change(d0, 20);
    rel_mask = '0;
    checks++;
    if (m_done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL enc_done dones=%0d required=1", m_done_cnt - d0);
    end
    s = q.size();
    checks++;
    if (s != 0) begin
      errors++;
      $display("FAIL enc_queue leftover=%0d required=0", s);
    end
  endtask

  task automatic test_dec();
    int d0;
    int sb;
    hold = '{10, 10, 10, 10};
    d0 = m_done_cnt;
    pulse_start(2'(DEC), 1);
    wait_done_change(d0, 100);
    sb = 0;
    for (int b = 0; b < BC; b++) sb += cnt_b[b];
    checks++;
    if (m_done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL dec_done dones=%0d required=1", m_done_cnt - d0);
    end
    checks++;
    if (cnt_a[0] != 4 || sb != 0 || m_beats != 4) begin
      errors++;
      $display("FAIL dec_counts a0=%0d b_total=%0d beats=%0d required 4/0/4", cnt_a[0], sb, m_beats);
    end
  endtask

  task automatic test_zero_tasks();
    int r0;
    r0 = req_n[0] + req_n[1] + req_n[2] + req_n[3];
    pulse_start(2'(ENC), 0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL zero_cycle1 done=%b busy=%b required done=0 busy=1", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_cycle2 done=%b busy=%b required done=1 busy=0", done, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL zero_cycle3 done=%b required=0", done);
    end
    checks++;
    if (req_n[0] + req_n[1] + req_n[2] + req_n[3] != r0) begin
      errors++;
      $display("FAIL zero_reqs got=%0d required=%0d", req_n[0] + req_n[1] + req_n[2] + req_n[3], r0);
    end
  endtask

  task automatic test_start_ignored();
    int d0;
    hold = '{1000, 1000, 1000, 1000};
    d0 = m_done_cnt;
    pulse_start(2'(ENC), 1);
    repeat (3) tick();
    pulse_start(2'(DEC), 3);
    wait_strobes(8, 60);
    repeat (10) tick();
    rel_mask = 4'b1111;
    wait_done_change(d0, 20);
    rel_mask = '0;
    repeat (10) tick();
    checks++;
    if (m_done_cnt != d0 + 1 || m_req != 1) begin
      errors++;
      $display("FAIL ignored_start dones=%0d reqs=%0d required 1/1", m_done_cnt - d0, m_req);
    end
    checks++;
    if (cnt_a[0] != 4 || cnt_b[0] != 4 || task_cmd !== 2'(ENC)) begin
      errors++;
      $display("FAIL ignored_mode a0=%0d b0=%0d cmd=%0d required 4/4/ENC", cnt_a[0], cnt_b[0], task_cmd);
    end
  endtask

  task automatic test_wait_stall();
    int d0;
    int sa;
    hold = '{100, 3, 3, 3};
    d0 = m_done_cnt;
    pulse_start(2'(ENC), 6);
    wait_done_change(d0, 800);
    sa = 0;
    for (int b = 0; b < BC; b++) sa += cnt_a[b];
    checks++;
    if (m_done_cnt != d0 + 1 || m_req != 6 || sa != 24) begin
      errors++;
      $display("FAIL stall_run dones=%0d reqs=%0d a_total=%0d required 1/6/24", m_done_cnt - d0, m_req, sa);
    end
    checks++;
    if (req_cyc[4] - te0_cyc != 1) begin
      errors++;
      $display("FAIL stall_release req5_cyc=%0d end0_cyc=%0d required gap 1", req_cyc[4], te0_cyc);
    end
    checks++;
    if (req_cyc[4] - req_cyc[3] <= 50) begin
      errors++;
      $display("FAIL stall_wait gap=%0d required >50", req_cyc[4] - req_cyc[3]);
    end
  endtask

  task automatic test_backpressure();
    int d0;
    int s;
    hold = '{5, 5, 5, 5};
    toggle = 1;
    d0 = m_done_cnt;
    pulse_start(2'(ENC), 2);
    wait_done_change(d0, 200);
    toggle = 0;
    s = q.size();
    checks++;
    if (m_done_cnt != d0 + 1 || s != 0) begin
      errors++;
      $display("FAIL bp_done dones=%0d leftover=%0d required 1/0", m_done_cnt - d0, s);
    end
    checks++;
    if (cnt_a[0] != 4 || cnt_b[0] != 4 || cnt_a[1] != 4 || cnt_b[1] != 4) begin
      errors++;
      $display("FAIL bp_counts a0=%0d b0=%0d a1=%0d b1=%0d required 4 each",
               cnt_a[0], cnt_b[0], cnt_a[1], cnt_b[1]);
    end
  endtask

  task automatic test_reset_midrun();
    int d0;
    hold = '{1000, 1000, 1000, 1000};
    pulse_start(2'(ENC), 2);
    for (int i = 0; i < 50 && m_beats < NW + 1; i++) tick();
    checks++;
    if (m_beats < NW + 1) begin
      errors++;
      $display("FAIL midrun_reach beats=%0d required>=%0d", m_beats, NW + 1);
    end
    d0 = m_done_cnt;
    rst = 1'b1;
    #1;
    checks++;
    if (s_ready !== 1'b0 || task_req !== '0 || op_a_valid !== '0 || op_b_valid !== '0 ||
        busy !== 1'b0 || done !== 1'b0 || op_data !== '0 || task_cmd !== 2'd0) begin
      errors++;
      $display("FAIL midrun_outputs rdy=%b req=%b a=%b b=%b busy=%b done=%b data=%h required all 0",
               s_ready, task_req, op_a_valid, op_b_valid, busy, done, op_data);
    end
    repeat (3) tick();
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if (m_done_cnt != d0) begin
      errors++;
      $display("FAIL midrun_no_done dones=%0d required=0", m_done_cnt - d0);
    end
    hold = '{3, 3, 3, 3};
    pulse_start(2'(ENC), 1);
    wait_done_change(d0, 100);
    checks++;
    if (m_done_cnt != d0 + 1 || first_req !== 4'b0001 || cnt_a[0] != 4 || cnt_b[0] != 4) begin
      errors++;
      $display("FAIL midrun_restart dones=%0d first_req=%b a0=%0d b0=%0d required 1/0001/4/4",
               m_done_cnt - d0, first_req, cnt_a[0], cnt_b[0]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    mode = 2'd0;
    num_tasks = '0;
    test_reset();
    test_enc_basic();
    test_dec();
    test_zero_tasks();
    test_start_ignored();
    test_wait_stall();
    test_backpressure();
    test_reset_midrun();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
